freg_issue_buffer: RTL and testbench

- Consumer end of the fetch pipeline register. Accepts the 65-bit fetch bundle {runtime, pc[31:0], instr[31:0]} and holds it in a 2-entry skid buffer.
- Presents the unpacked fields to the decode stage under a valid/ready handshake, so decode can stall without losing fetched instructions.
- Optionally drops NOP bubbles (instr 32'h00000008) inserted by fetch wipes.
- Flushes on branch/jump redirect and keeps a saturating stall-cycle counter for performance debug.

---
 rtl/freg_issue_buffer_pkg.sv | 26 ++
 rtl/freg_issue_buffer_if.sv | 28 ++
 rtl/freg_skid_entry.sv | 55 +++++
 rtl/freg_issue_buffer.sv | 146 ++++++++++++++
 tb/tb_freg_issue_buffer.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/freg_issue_buffer_pkg.sv
// Shared fetch-pipeline definitions: bundle layout, bubble encoding and
// helpers used by the fetch register and the issue buffer.
package freg_issue_buffer_pkg;

    localparam int          FETCH_BUNDLE_W = 65;
    localparam int          RUNTIME_BIT    = 64;
    localparam int          PC_MSB         = 63;
    localparam int          PC_LSB         = 32;
    localparam int          INSTR_MSB      = 31;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0008;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    function automatic logic [FETCH_BUNDLE_W-1:0] make_bundle(
        input logic        runtime,
        input logic [31:0] pc,
        input logic [31:0] instr
    );
        return {runtime, pc, instr};
    endfunction

endpackage

// File: rtl/freg_issue_buffer_if.sv
// Fetch-to-decode handshake bundle; the buffer takes the slave side.
interface freg_issue_buffer_if
    import freg_issue_buffer_pkg::*;
#(
    parameter int STALL_W = 16
);
    logic [FETCH_BUNDLE_W-1:0] in_bundle;
    logic                      in_valid;
    logic                      in_ready;
    logic                      flush;
    logic                      out_valid;
    logic                      out_ready;
    logic                      out_runtime;
    logic [31:0]               out_pc;
    logic [31:0]               out_instr;
    logic [1:0]                count;
    logic [STALL_W-1:0]        stall_cycles;

    modport master (
        output in_bundle, in_valid, flush, out_ready,
        input  in_ready, out_valid, out_runtime, out_pc, out_instr, count, stall_cycles
    );

    modport slave (
        input  in_bundle, in_valid, flush, out_ready,
        output in_ready, out_valid, out_runtime, out_pc, out_instr, count, stall_cycles
    );
endinterface

// File: rtl/freg_skid_entry.sv
// One holding register of the skid buffer. Clear restores the idle value,
// invalidate drops the valid bit but keeps the data visible.
module freg_skid_entry #(
    parameter int             W         = 65,
    parameter logic [W-1:0]   CLEAR_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic         invalidate_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic         valid_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    // Next-state selection: clear beats load beats invalidate.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
            data_d  = CLEAR_VAL;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (invalidate_i) begin
            valid_d = 1'b0;
            data_d  = data_q;
        end else begin
            valid_d = valid_q;
            data_d  = data_q;
        end
    end

    // Entry state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= CLEAR_VAL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/freg_issue_buffer.sv
// Decode-side skid buffer for fetch bundles: 2-entry FIFO with flush,
// optional bubble dropping and a saturating decode-stall counter.
module freg_issue_buffer
    import freg_issue_buffer_pkg::*;
#(
    parameter int          DEPTH     = 2,
    parameter bit          DROP_NOP  = 1'b1,
    parameter logic [31:0] NOP_INSTR = freg_issue_buffer_pkg::NOP_INSTR,
    parameter int          STALL_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    freg_issue_buffer_if.slave  bus
);

    localparam logic [FETCH_BUNDLE_W-1:0] IDLE_BUNDLE = make_bundle(1'b0, 32'h0000_0000, NOP_INSTR);
    localparam logic [1:0]                FULL_CNT    = 2'(DEPTH);

    logic                      head_valid_s;
    logic                      tail_valid_s;
    logic [FETCH_BUNDLE_W-1:0] head_data_s;
    logic [FETCH_BUNDLE_W-1:0] tail_data_s;
    logic [FETCH_BUNDLE_W-1:0] head_din_s;
    logic                      head_load_s;
    logic                      head_inv_s;
    logic                      tail_load_s;
    logic                      tail_inv_s;
    logic                      in_ready_s;
    logic                      is_nop_s;
    logic                      push_s;
    logic                      pop_s;
    occ_e                      occ_s;
    logic [STALL_W-1:0]        stall_q;
    logic [STALL_W-1:0]        stall_d;

    // Occupancy comes straight from the entry valid flops (tail only valid when head is).
    always_comb begin
        occ_s = OCC_EMPTY;
        if (tail_valid_s) begin
            occ_s = OCC_FULL;
        end else if (head_valid_s) begin
            occ_s = OCC_ONE;
        end else begin
            occ_s = OCC_EMPTY;
        end
    end

    assign in_ready_s = (occ_s != FULL_CNT);

    // Handshake qualification and per-entry load/invalidate steering.
    always_comb begin
        is_nop_s    = DROP_NOP && (bus.in_bundle[INSTR_MSB:0] == NOP_INSTR);
        push_s      = bus.in_valid & in_ready_s & ~bus.flush & ~is_nop_s;
        pop_s       = head_valid_s & bus.out_ready & ~bus.flush;
        head_din_s  = bus.in_bundle;
        head_load_s = 1'b0;
        head_inv_s  = 1'b0;
        tail_load_s = 1'b0;
        tail_inv_s  = 1'b0;
        case (occ_s)
            OCC_EMPTY: begin
                head_load_s = push_s;
            end
            OCC_ONE: begin
                if (push_s && pop_s) begin
                    head_load_s = 1'b1;
                end else if (push_s) begin
                    tail_load_s = 1'b1;
                end else if (pop_s) begin
                    head_inv_s = 1'b1;
                end else begin
                    head_load_s = 1'b0;
                end
            end
            OCC_FULL: begin
                // Full: in_ready is low, so only a pop can happen; tail slides forward.
                if (pop_s) begin
                    head_load_s = 1'b1;
                    head_din_s  = tail_data_s;
                    tail_inv_s  = 1'b1;
                end else begin
                    head_load_s = 1'b0;
                end
            end
            default: begin
                head_load_s = 1'b0;
            end
        endcase
    end

    freg_skid_entry #(
        .W         (FETCH_BUNDLE_W),
        .CLEAR_VAL (IDLE_BUNDLE)
    ) u_head (
        .clk          (clk),
        .rst_n        (reset),
        .clear_i      (bus.flush),
        .load_i       (head_load_s),
        .invalidate_i (head_inv_s),
        .data_i       (head_din_s),
        .valid_o      (head_valid_s),
        .data_o       (head_data_s)
    );

    freg_skid_entry #(
        .W         (FETCH_BUNDLE_W),
        .CLEAR_VAL (IDLE_BUNDLE)
    ) u_tail (
        .clk          (clk),
        .rst_n        (reset),
        .clear_i      (bus.flush),
        .load_i       (tail_load_s),
        .invalidate_i (tail_inv_s),
        .data_i       (bus.in_bundle),
        .valid_o      (tail_valid_s),
        .data_o       (tail_data_s)
    );

    // Stall counter: decode holding off a valid head; saturates, survives flush.
    always_comb begin
        stall_d = stall_q;
        if (head_valid_s && !bus.out_ready && !(&stall_q)) begin
            stall_d = stall_q + {{(STALL_W-1){1'b0}}, 1'b1};
        end else begin
            stall_d = stall_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= {STALL_W{1'b0}};
        end else begin
            stall_q <= stall_d;
        end
    end

    assign bus.in_ready     = in_ready_s;
    assign bus.out_valid    = head_valid_s;
    assign bus.out_runtime  = head_data_s[RUNTIME_BIT];
    assign bus.out_pc       = head_data_s[PC_MSB:PC_LSB];
    assign bus.out_instr    = head_data_s[INSTR_MSB:0];
    assign bus.count        = occ_s;
    assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_freg_issue_buffer.sv
// Directed bench for freg_issue_buffer: one instance with bubble dropping,
// one without, driven through the handshake interface.
module tb_freg_issue_buffer;
    import freg_issue_buffer_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    freg_issue_buffer_if #(.STALL_W(16)) bus_if  ();
    freg_issue_buffer_if #(.STALL_W(16)) bus0_if ();

    freg_issue_buffer #(
        .DEPTH(2), .DROP_NOP(1'b1), .NOP_INSTR(32'h0000_0008), .STALL_W(16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    freg_issue_buffer #(
        .DEPTH(2), .DROP_NOP(1'b0), .NOP_INSTR(32'h0000_0008), .STALL_W(16)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rt, input logic [31:0] pc, input logic [31:0] instr);
        bus_if.in_valid  = v;
        bus_if.in_bundle = make_bundle(rt, pc, instr);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        bus_if.in_valid   = 1'b0;
        bus_if.in_bundle  = '0;
        bus_if.flush      = 1'b0;
        bus_if.out_ready  = 1'b1;
        bus0_if.in_valid  = 1'b0;
        bus0_if.in_bundle = '0;
        bus0_if.flush     = 1'b0;
        bus0_if.out_ready = 1'b1;
        tick();
        tick();
        chk("rst_count",   64'(bus_if.count),        64'd0);
        chk("rst_valid",   64'(bus_if.out_valid),    64'd0);
        chk("rst_instr",   64'(bus_if.out_instr),    64'h8);
        chk("rst_pc",      64'(bus_if.out_pc),       64'h0);
        chk("rst_runtime", 64'(bus_if.out_runtime),  64'd0);
        chk("rst_stall",   64'(bus_if.stall_cycles), 64'd0);
        chk("rst_ready",   64'(bus_if.in_ready),     64'd1);
        reset = 1'b1;
        tick();

        // Single push, consumed immediately
        drive(1'b1, 1'b1, 32'h0000_0100, 32'h8C22_0004);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        chk("t1_valid",   64'(bus_if.out_valid),   64'd1);
        chk("t1_runtime", 64'(bus_if.out_runtime), 64'd1);
        chk("t1_pc",      64'(bus_if.out_pc),      64'h100);
        chk("t1_instr",   64'(bus_if.out_instr),   64'h8C22_0004);
        chk("t1_count",   64'(bus_if.count),       64'd1);
        tick();
        chk("t1_drain_valid", 64'(bus_if.out_valid), 64'd0);
        chk("t1_drain_count", 64'(bus_if.count),     64'd0);

        // Fill while decode stalls, overflow attempt ignored, then drain in order
        bus_if.out_ready = 1'b0;
        drive(1'b1, 1'b0, 32'h0000_0104, 32'h2001_0104);
        tick();
        chk("t2_count1", 64'(bus_if.count), 64'd1);
        drive(1'b1, 1'b0, 32'h0000_0108, 32'h2001_0108);
        tick();
        chk("t2_count2", 64'(bus_if.count),    64'd2);
        chk("t2_full",   64'(bus_if.in_ready), 64'd0);
        drive(1'b1, 1'b0, 32'h0000_010C, 32'h2001_010C);
        tick();
        chk("t2_ovf_count", 64'(bus_if.count),  64'd2);
        chk("t2_ovf_head",  64'(bus_if.out_pc), 64'h104);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk("t2_stall_held", 64'(bus_if.stall_cycles), 64'd3);
        bus_if.out_ready = 1'b1;
        chk("t2_first", 64'(bus_if.out_pc), 64'h104);
        tick();
        chk("t2_second",  64'(bus_if.out_pc),    64'h108);
        chk("t2_valid2",  64'(bus_if.out_valid), 64'd1);
        chk("t2_count_a", 64'(bus_if.count),     64'd1);
        chk("t2_ready_b", 64'(bus_if.in_ready),  64'd1);
        tick();
        chk("t2_empty", 64'(bus_if.count),        64'd0);
        chk("t2_stall", 64'(bus_if.stall_cycles), 64'd3);

        // Bubble: dropped by dut, kept by dut0
        drive(1'b1, 1'b0, 32'h0000_0110, 32'h0000_0008);
        bus0_if.in_valid  = 1'b1;
        bus0_if.in_bundle = make_bundle(1'b0, 32'h0000_0110, 32'h0000_0008);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        bus0_if.in_valid = 1'b0;
        chk("t3_drop_count", 64'(bus_if.count),      64'd0);
        chk("t3_drop_valid", 64'(bus_if.out_valid),  64'd0);
        chk("t3_keep_valid", 64'(bus0_if.out_valid), 64'd1);
        chk("t3_keep_instr", 64'(bus0_if.out_instr), 64'h8);
        chk("t3_keep_pc",    64'(bus0_if.out_pc),    64'h110);

        // Flush when full; bundle in flush cycle dropped; redirect accepted after
        bus_if.out_ready = 1'b0;
        drive(1'b1, 1'b0, 32'h0000_01A0, 32'h2001_01A0);
        tick();
        drive(1'b1, 1'b0, 32'h0000_01A4, 32'h2001_01A4);
        tick();
        chk("t4_full", 64'(bus_if.count), 64'd2);
        drive(1'b1, 1'b0, 32'h0000_0200, 32'h2001_0200);
        bus_if.flush = 1'b1;
        tick();
        bus_if.flush = 1'b0;
        chk("t4_fl_count", 64'(bus_if.count),     64'd0);
        chk("t4_fl_valid", 64'(bus_if.out_valid), 64'd0);
        chk("t4_fl_instr", 64'(bus_if.out_instr), 64'h8);
        drive(1'b1, 1'b0, 32'h0000_0300, 32'h2001_0300);
        tick();
        chk("t4_redir_pc",    64'(bus_if.out_pc),       64'h300);
        chk("t4_redir_count", 64'(bus_if.count),        64'd1);
        chk("t4_stall_kept",  64'(bus_if.stall_cycles), 64'd5);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        bus_if.out_ready = 1'b1;
        tick();
        chk("t4_drain", 64'(bus_if.count), 64'd0);

        // Simultaneous push and pop at count 1 replaces the head
        bus_if.out_ready = 1'b0;
        drive(1'b1, 1'b0, 32'h0000_0120, 32'h2001_0120);
        tick();
        chk("t5_head", 64'(bus_if.out_pc), 64'h120);
        bus_if.out_ready = 1'b1;
        drive(1'b1, 1'b0, 32'h0000_0124, 32'h2001_0124);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        chk("t5_count", 64'(bus_if.count),     64'd1);
        chk("t5_pc",    64'(bus_if.out_pc),    64'h124);
        chk("t5_instr", 64'(bus_if.out_instr), 64'h2001_0124);
        tick();
        chk("t5_empty", 64'(bus_if.count), 64'd0);

        // Asynchronous reset in the middle of a cycle with the buffer full
        bus_if.out_ready = 1'b0;
        drive(1'b1, 1'b1, 32'h0000_0400, 32'h2001_0400);
        tick();
        drive(1'b1, 1'b1, 32'h0000_0404, 32'h2001_0404);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        chk("t6_pre_count", 64'(bus_if.count),        64'd2);
        chk("t6_pre_stall", 64'(bus_if.stall_cycles), 64'd6);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_count",   64'(bus_if.count),        64'd0);
        chk("t6_valid",   64'(bus_if.out_valid),    64'd0);
        chk("t6_ready",   64'(bus_if.in_ready),     64'd1);
        chk("t6_instr",   64'(bus_if.out_instr),    64'h8);
        chk("t6_pc",      64'(bus_if.out_pc),       64'h0);
        chk("t6_runtime", 64'(bus_if.out_runtime),  64'd0);
        chk("t6_stall",   64'(bus_if.stall_cycles), 64'd0);
        tick();
        reset = 1'b1;
        tick();

        // Stall counter saturation
        drive(1'b1, 1'b0, 32'h0000_0500, 32'h2001_0500);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        chk("t7_start", 64'(bus_if.stall_cycles), 64'd0);
        repeat (65534) @(posedge clk);
        #1;
        chk("t7_fffe", 64'(bus_if.stall_cycles), 64'hFFFE);
        repeat (5) @(posedge clk);
        #1;
        chk("t7_sat",  64'(bus_if.stall_cycles), 64'hFFFF);
        chk("t7_head", 64'(bus_if.out_pc),       64'h500);
        bus_if.out_ready = 1'b1;
        tick();
        chk("t7_sat_hold", 64'(bus_if.stall_cycles), 64'hFFFF);
        chk("t7_popped",   64'(bus_if.count),        64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
